// File: rtl/ps2_disp_ctrl.sv
// ps2_disp_ctrl: PS/2 hex-key scan-code sequencer and multiplexed 7-segment display driver.
// Drops break (F0 xx) and extended (E0 xx / E0 F0 xx) sequences, keeps the last NDIG hex
// make codes in a shift buffer, and scans them across NDIG common-anode digits through an
// external scan-code-to-segment transcoder.
// Optional feature: define PS2_REPEAT_FILTER_EN to suppress typematic repeats of the last
// stored key until its break code is seen.
module ps2_disp_ctrl #(
  parameter int unsigned NDIG        = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         code_valid,
  input  logic [7:0]                   code,
  input  logic                         clr,
  output logic [7:0]                   code_out,
  input  logic [6:0]                   seg_in,
  output logic [6:0]                   seg,
  output logic [NDIG-1:0]              an,
  output logic [$clog2(NDIG+1)-1:0]    count
);

  localparam int unsigned IW = $clog2(NDIG);
  localparam int unsigned CW = $clog2(NDIG + 1);
  localparam int unsigned DW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {StIdle, StExt, StBreak} state_e;

  state_e          state_q;
  logic [7:0]      slot_q [NDIG];
  logic [CW-1:0]   count_q;
  logic [DW-1:0]   div_q;
  logic [IW-1:0]   idx_q;
  logic [6:0]      seg_q;
  logic [NDIG-1:0] an_q;
  logic            is_hex;
  logic            store;
  logic            occupied;

  // Recognise the 16 hex-key make codes.
  always_comb begin
    is_hex = 1'b0;
    case (code)
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
      8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B: is_hex = 1'b1;
      default:                                               is_hex = 1'b0;
    endcase
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [7:0] hold_q;
  logic       hold_vld_q;

  // A held key repeats its make code; only the first one is stored.
  always_comb begin
    store = code_valid && (state_q == StIdle) && is_hex && !(hold_vld_q && (code == hold_q));
  end

  // Track the last stored key until its break code releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
    end else if (clr) begin
      hold_vld_q <= 1'b0;
    end else if (store) begin
      hold_q     <= code;
      hold_vld_q <= 1'b1;
    end else if (code_valid && (state_q == StBreak) && (code == hold_q)) begin
      hold_vld_q <= 1'b0;
    end
  end
`else
  // Every hex make code seen in IDLE is stored, repeats included.
  always_comb begin
    store = code_valid && (state_q == StIdle) && is_hex;
  end
`endif

  // Byte FSM: strips F0/E0 prefixes and the byte that follows them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (code_valid) begin
      unique case (state_q)
        StIdle: begin
          if (code == 8'hF0)      state_q <= StBreak;
          else if (code == 8'hE0) state_q <= StExt;
        end
        StExt:   state_q <= (code == 8'hF0) ? StBreak : StIdle;
        StBreak: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Key buffer: newest key in slot 0, oldest falls off the top when full; clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int k = 0; k < NDIG; k++) slot_q[k] <= 8'h00;
    end else if (clr) begin
      count_q <= '0;
    end else if (store) begin
      for (int k = NDIG - 1; k > 0; k--) slot_q[k] <= slot_q[k-1];
      slot_q[0] <= code;
      if (count_q != CW'(NDIG)) count_q <= count_q + 1'b1;
    end
  end

  // Slots fill from 0 upward, so a slot is occupied exactly when its index is below count.
  always_comb begin
    occupied = (CW'(idx_q) < count_q);
    code_out = occupied ? slot_q[idx_q] : 8'h00;
  end

  // Refresh scan and registered digit drive; seg and an move together one cycle after idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      seg_q <= 7'h7F;
      an_q  <= '1;
    end else begin
      if (div_q == DW'(REFRESH_DIV - 1)) begin
        div_q <= '0;
        idx_q <= (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      an_q  <= ~(NDIG'(1) << idx_q);
      seg_q <= occupied ? seg_in : 7'h7F;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign count = count_q;

endmodule

// File: tb/tb_ps2_disp_ctrl.sv
// tb_ps2_disp_ctrl: directed self-checking bench for ps2_disp_ctrl (NDIG=4, REFRESH_DIV=4).
// Build with PS2_REPEAT_FILTER_EN defined to exercise the repeat filter expectations.
module tb_ps2_disp_ctrl;

  localparam int unsigned NDIG = 4;
  localparam int unsigned RDIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       code_valid;
  logic [7:0] code;
  logic       clr;
  logic [7:0] code_out;
  logic [6:0] seg_in;
  logic [6:0] seg;
  logic [3:0] an;
  logic [2:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_disp_ctrl #(
    .NDIG        (NDIG),
    .REFRESH_DIV (RDIV)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code       (code),
    .clr        (clr),
    .code_out   (code_out),
    .seg_in     (seg_in),
    .seg        (seg),
    .an         (an),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Board transcoder model: scan code to active-low a..g hex glyph.
  function automatic logic [6:0] xcode(input logic [7:0] c);
    case (c)
      8'h45: return 7'b0000001;  8'h16: return 7'b1001111;
      8'h1E: return 7'b0010010;  8'h26: return 7'b0000110;
      8'h25: return 7'b1001100;  8'h2E: return 7'b0100100;
      8'h36: return 7'b0100000;  8'h3D: return 7'b0001111;
      8'h3E: return 7'b0000000;  8'h46: return 7'b0000100;
      8'h1C: return 7'b0001000;  8'h32: return 7'b1100000;
      8'h21: return 7'b0110001;  8'h23: return 7'b1000010;
      8'h24: return 7'b0110000;  8'h2B: return 7'b0111000;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb seg_in = xcode(code_out);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; code_valid = 1'b0; clr = 1'b0; code = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code = b; code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Wait for the first cycle digit k is lit; code_out and seg then both belong to slot k.
  task automatic grab_digit(input int k, output logic [7:0] c, output logic [6:0] s);
    logic [3:0] tgt;
    int n;
    tgt = ~(4'b0001 << k);
    n = 0;
    while (an == tgt && n < 100) begin @(negedge clk); n++; end
    while (an != tgt && n < 100) begin @(negedge clk); n++; end
    check("scan_timeout", 32'(n >= 100), 32'd0);
    c = code_out;
    s = seg;
  endtask

  logic [7:0] c;
  logic [6:0] s;
  logic [6:0] exp_s;
  int d;

  initial begin
    rst = 1'b1; code_valid = 1'b0; clr = 1'b0; code = 8'h00;

    // Reset state, sampled while rst is still asserted.
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_count", 32'(count), 32'd0);
    check("rst_code_out", 32'(code_out), 32'h00);

    // T5: an walks E,D,B,7,E in 4-cycle steps from reset release.
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check("t5_an", 32'(an), 32'(4'(~(4'b0001 << (((k - 1) / 4) % 4)))));
    end
    check("t5_seg_empty", 32'(seg), 32'h7F);

    // Seg follows the lit digit's transcoder result with the same latency as an.
    send(8'h16);
    send(8'h1E);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      d = -1;
      for (int j = 0; j < 4; j++) if (an == 4'(~(4'b0001 << j))) d = j;
      exp_s = (d == 0) ? 7'b0010010 : (d == 1) ? 7'b1001111 : (d < 0) ? 7'h00 : 7'h7F;
      check("t5_seg_track", 32'(seg), 32'(exp_s));
    end

    // T1: three keys fill slots newest-first; slot 3 stays blank.
    do_reset();
    send(8'h16); send(8'h1E); send(8'h26);
    check("t1_count", 32'(count), 32'd3);
    grab_digit(0, c, s);
    check("t1_d0_code", 32'(c), 32'h26);
    check("t1_d0_seg", 32'(s), 32'b0000110);
    grab_digit(1, c, s);
    check("t1_d1_code", 32'(c), 32'h1E);
    grab_digit(2, c, s);
    check("t1_d2_code", 32'(c), 32'h16);
    grab_digit(3, c, s);
    check("t1_d3_code", 32'(c), 32'h00);
    check("t1_d3_seg", 32'(s), 32'h7F);

    // T2: make/break of one key stores once; FSM ends in IDLE.
    pulse_clr();
    check("t2_clr_count", 32'(count), 32'd0);
    send(8'h16); send(8'hF0); send(8'h16);
    check("t2_count", 32'(count), 32'd1);
    send(8'h1E);
    check("t2_idle_count", 32'(count), 32'd2);
    grab_digit(0, c, s);
    check("t2_d0_code", 32'(c), 32'h1E);

    // clr leaves the FSM alone: a pending break still eats the next byte.
    pulse_clr();
    send(8'hF0);
    pulse_clr();
    send(8'h16);
    check("t2_clr_keeps_fsm", 32'(count), 32'd0);
    send(8'h16);
    check("t2_after_break", 32'(count), 32'd1);

    // T3: extended break, unknown byte and extended make are all dropped.
    pulse_clr();
    send(8'hE0); send(8'hF0); send(8'h75); send(8'h45);
    check("t3_count", 32'(count), 32'd1);
    grab_digit(0, c, s);
    check("t3_d0_code", 32'(c), 32'h45);
    check("t3_d0_seg", 32'(s), 32'b0000001);
    send(8'h75);
    check("t3_unknown", 32'(count), 32'd1);
    send(8'hE0); send(8'h16);
    check("t3_ext_make", 32'(count), 32'd1);

    // T4: overflow drops the oldest; clr beats a simultaneous store.
    pulse_clr();
    send(8'h45); send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    check("t4_count_sat", 32'(count), 32'd4);
    grab_digit(0, c, s);
    check("t4_d0_code", 32'(c), 32'h25);
    grab_digit(3, c, s);
    check("t4_d3_code", 32'(c), 32'h16);
    check("t4_d3_seg", 32'(s), 32'b1001111);
    @(negedge clk);
    clr = 1'b1; code_valid = 1'b1; code = 8'h2E;
    @(negedge clk);
    clr = 1'b0; code_valid = 1'b0;
    check("t4_clr_wins", 32'(count), 32'd0);
    grab_digit(0, c, s);
    check("t4_blank_code", 32'(c), 32'h00);
    check("t4_blank_seg", 32'(s), 32'h7F);

    // T6: typematic repeats.
    send(8'h16); send(8'h16); send(8'h16);
`ifdef PS2_REPEAT_FILTER_EN
    check("t6_repeat", 32'(count), 32'd1);
`else
    check("t6_repeat", 32'(count), 32'd3);
`endif
    send(8'hF0); send(8'h16); send(8'h16);
`ifdef PS2_REPEAT_FILTER_EN
    check("t6_release", 32'(count), 32'd2);
`else
    check("t6_release", 32'(count), 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
